// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared memory widths and arbiter state encoding.
package mem_arbiter_pkg;
  localparam int MEMORY_ADDRESS_BITS = 8;
  localparam int MEMORY_DATA_BITS = 8;
  localparam int NUM_REQ = 2;
  typedef enum logic [1:0] {IDLE, ISSUE, COMPLETE} arb_state_t;
endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin selector; on a tie the requester that did not go last wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       gnt
);
  assign valid = |req;
  assign gnt = (&req) ? ~last : req[1];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sequencer sharing a single-port RAM between two requesters,
// one access per two cycles with an optional per-requester lock.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_BITS = MEMORY_ADDRESS_BITS,
  parameter int DATA_BITS = MEMORY_DATA_BITS
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             m_req,
  input  logic [NUM_REQ-1:0]             m_we,
  input  logic [NUM_REQ-1:0]             m_lock,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   m_addr,
  input  logic [NUM_REQ*DATA_BITS-1:0]   m_wdata,
  output logic [DATA_BITS-1:0]           m_rdata,
  output logic [NUM_REQ-1:0]             m_done,
  output logic [ADDR_BITS-1:0]           ram_address,
  inout  wire  [DATA_BITS-1:0]           ram_data,
  output logic                           ram_read_en,
  output logic                           ram_write_en
);
  arb_state_t r_state, w_next;
  logic r_gnt, r_last, r_wr;
  logic [ADDR_BITS-1:0] r_addr;
  logic [DATA_BITS-1:0] r_wdata, r_rdata;
  logic w_last, w_valid, w_pick, w_keep, w_sel, w_take;
  // COMPLETE arbitrates against the requester just finished, i.e. the updated last
  assign w_last = (r_state == COMPLETE) ? r_gnt : r_last;
  rr_pick2 u_pick (
    .req  (m_req),
    .last (w_last),
    .valid(w_valid),
    .gnt  (w_pick)
  );
  always_comb begin
    w_keep = (r_state == COMPLETE) && m_lock[r_gnt] && m_req[r_gnt];
    w_sel = w_keep ? r_gnt : w_pick;
    w_take = w_keep || (w_valid && r_state != ISSUE);
    w_next = (r_state == ISSUE) ? COMPLETE : (w_take ? ISSUE : IDLE);
    ram_read_en = (r_state == ISSUE) && !r_wr;
    ram_write_en = (r_state == ISSUE) && r_wr;
    m_done = (r_state == COMPLETE) ? (2'b01 << r_gnt) : 2'b00;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gnt <= 1'b0;
      r_last <= 1'b1;
      r_wr <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (r_state == COMPLETE) r_last <= r_gnt;
      if (w_take) begin
        r_gnt <= w_sel;
        r_wr <= m_we[w_sel];
        r_addr <= w_sel ? m_addr[2*ADDR_BITS-1:ADDR_BITS] : m_addr[ADDR_BITS-1:0];
        r_wdata <= w_sel ? m_wdata[2*DATA_BITS-1:DATA_BITS] : m_wdata[DATA_BITS-1:0];
      end
      if (ram_read_en) r_rdata <= ram_data;
    end
  end
  assign m_rdata = r_rdata;
  assign ram_address = r_addr;
  assign ram_data = ram_write_en ? r_wdata : 'z;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: transaction-level model of the arbiter (per-requester queues, predicted
// completion cycle and winner) checked against the DUT with a behavioural RAM attached.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;
  localparam int AW = MEMORY_ADDRESS_BITS;
  localparam int DW = MEMORY_DATA_BITS;
  typedef struct packed {logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata;} acc_t;
  logic clk = 0, reset = 0, ram_clr = 1;
  logic [1:0] m_req = 0, m_we = 0, m_lock = 0, m_done;
  logic [2*AW-1:0] m_addr = 0;
  logic [2*DW-1:0] m_wdata = 0;
  logic [DW-1:0] m_rdata;
  logic [AW-1:0] ram_address;
  wire [DW-1:0] ram_data;
  logic ram_read_en, ram_write_en;
  logic [DW-1:0] mem_ram [2**AW];
  logic [DW-1:0] mem_ref [2**AW];
  acc_t q0[$], q1[$];
  acc_t cur;
  int exp_who = -1, exp_at = 0, cyc = 0, last = 1, tests = 0, fails = 0;
  int dseq[$];
  logic [DW-1:0] rd_val = 0;
  logic [1:0] lk = 0;
  logic [DW-1:0] ld [3];

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset(reset), .m_req(m_req), .m_we(m_we), .m_lock(m_lock),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_done(m_done),
    .ram_address(ram_address), .ram_data(ram_data),
    .ram_read_en(ram_read_en), .ram_write_en(ram_write_en)
  );

  assign ram_data = ram_read_en ? mem_ram[ram_address] : 'z;
  always @(posedge clk) begin
    if (ram_clr) for (int k = 0; k < 2**AW; k++) mem_ram[k] <= '0;
    else if (ram_write_en) mem_ram[ram_address] <= ram_data;
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%0h exp=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic acc_t mk(logic we, logic [AW-1:0] a, logic [DW-1:0] d);
    mk = '{we: we, addr: a, wdata: d};
  endfunction

  function automatic acc_t rnd();
    rnd = mk(1'($urandom_range(1)), AW'($urandom_range(15)), DW'($urandom));
  endfunction

  function automatic int pick(logic [1:0] r, int l);
    if (r == 2'b11) return 1 - l;
    if (r[1]) return 1;
    if (r[0]) return 0;
    return -1;
  endfunction

  task automatic drive();
    acc_t a0, a1;
    a0 = (q0.size() != 0) ? q0[0] : '0;
    a1 = (q1.size() != 0) ? q1[0] : '0;
    m_req = {q1.size() != 0, q0.size() != 0};
    m_lock = lk;
    m_we = {a1.we, a0.we};
    m_addr = {a1.addr, a0.addr};
    m_wdata = {a1.wdata, a0.wdata};
  endtask

  // decides who the edge ending the current cycle grants, and when that access completes
  task automatic predict();
    logic done_now;
    int nx;
    if (!reset) return;
    if (exp_who >= 0 && exp_at == cyc + 1) return;
    done_now = exp_who >= 0 && exp_at == cyc;
    if (done_now) last = exp_who;
    nx = (done_now && lk[exp_who] && m_req[exp_who]) ? exp_who : pick(m_req, last);
    if (nx >= 0) begin
      cur = (nx == 1) ? q1[0] : q0[0];
      exp_who = nx;
      exp_at = cyc + 2;
    end else exp_who = -1;
  endtask

  task automatic check();
    logic is_done, is_issue;
    is_done = exp_who >= 0 && exp_at == cyc;
    is_issue = exp_who >= 0 && exp_at == cyc + 1;
    chk("done", 32'(m_done), is_done ? (32'd1 << exp_who) : 32'd0);
    if (is_done && !cur.we) rd_val = mem_ref[cur.addr];
    chk("rdata", 32'(m_rdata), 32'(rd_val));
    chk("read_en", 32'(ram_read_en), 32'(is_issue && !cur.we));
    chk("write_en", 32'(ram_write_en), 32'(is_issue && cur.we));
    chk("both_en", 32'(ram_read_en & ram_write_en), 32'd0);
    if (is_issue) begin
      chk("address", 32'(ram_address), 32'(cur.addr));
      chk("bus", 32'(ram_data), cur.we ? 32'(cur.wdata) : 32'(mem_ram[cur.addr]));
    end
    if (is_done) begin
      if (cur.we) mem_ref[cur.addr] = cur.wdata;
      dseq.push_back(exp_who);
      if (exp_who == 0) void'(q0.pop_front());
      else void'(q1.pop_front());
    end
  endtask

  task automatic step();
    drive();
    predict();
    @(posedge clk);
    #1;
    cyc++;
    check();
  endtask

  function automatic logic pending();
    return q0.size() != 0 || q1.size() != 0 || (exp_who >= 0 && exp_at > cyc);
  endfunction

  task automatic drain();
    for (int k = 0; k < 200 && pending(); k++) step();
    chk("drain", 32'(pending()), 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 2**AW; k++) mem_ref[k] = '0;
    repeat (2) step();
    ram_clr = 0;
    reset = 1;
    repeat (10) step();
    dseq.delete();
    repeat (4) begin
      q0.push_back(mk(0, AW'($urandom_range(15)), 0));
      q1.push_back(mk(0, AW'($urandom_range(15)), 0));
    end
    drain();
    chk("contend_cnt", 32'(dseq.size()), 32'd8);
    for (int i = 0; i < 8; i++) chk("contend_order", 32'(dseq[i]), 32'(i % 2));
    q0.push_back(mk(1, 3, 8'h5A));
    q0.push_back(mk(0, 3, 0));
    drain();
    chk("wr_rd", 32'(m_rdata), 32'h5A);
    lk = 2'b10;
    for (int i = 0; i < 3; i++) begin
      ld[i] = DW'($urandom);
      q1.push_back(mk(1, AW'(10 + i), ld[i]));
    end
    step();
    q0.push_back(mk(0, 5, 0));
    dseq.delete();
    drain();
    lk = 2'b00;
    chk("lock_cnt", 32'(dseq.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("lock_order", 32'(dseq[i]), (i < 3) ? 32'd1 : 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("lock_ram", 32'(mem_ram[10 + i]), 32'(ld[i]));
      q0.push_back(mk(0, AW'(10 + i), 0));
    end
    drain();
    repeat (400) begin
      if ($urandom_range(3) == 0 && q0.size() < 3) q0.push_back(rnd());
      if ($urandom_range(3) == 0 && q1.size() < 3) q1.push_back(rnd());
      if ($urandom_range(15) == 0) lk = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b00;
      step();
    end
    lk = 2'b00;
    drain();
    q0.push_back(mk(1, 20, 8'hC3));
    step();
    chk("mid_issue", 32'(ram_write_en), 32'd1);
    reset = 0;
    #1;
    chk("rst_we", 32'(ram_write_en), 32'd0);
    chk("rst_re", 32'(ram_read_en), 32'd0);
    chk("rst_done", 32'(m_done), 32'd0);
    chk("rst_addr", 32'(ram_address), 32'd0);
    chk("rst_rdata", 32'(m_rdata), 32'd0);
    exp_who = -1;
    last = 1;
    rd_val = '0;
    q0.delete();
    q1.delete();
    repeat (2) step();
    reset = 1;
    dseq.delete();
    q0.push_back(mk(0, 20, 0));
    q1.push_back(mk(0, 20, 0));
    drain();
    chk("rst_first", 32'(dseq[0]), 32'd0);
    chk("rst_abandon", 32'(mem_ram[20]), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
